// File: rtl/seven_seg_scan_controller.sv
// Scans NUM_DIGITS 3-bit codes onto a shared 7-segment decoder with blank gaps.
// Frames are double-buffered so a new frame only takes effect at a frame boundary.
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [3*NUM_DIGITS-1:0] wr_digits,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    output logic [2:0]              dec_code,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    seg_off,
    output logic [1:0]              dbg_state
);

    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d, idx_next;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    commit;

    logic [3*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [3*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_full_q, pend_full_d;
    logic                    wr_ready_q;

    logic [2:0]              dec_code_q, dec_code_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    seg_off_q, seg_off_d;

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    // Scan sequencing; commit marks the end of the last digit's slot, or any OFF cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        commit  = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
            commit  = (state_q == ST_OFF);
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (GAP_CYCLES == 0) begin
                            idx_d  = idx_next;
                            commit = (idx_q == IDX_LAST);
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        idx_d   = idx_next;
                        commit  = (idx_q == IDX_LAST);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Handshake: a frame transfers on any cycle where wr_valid && wr_ready are both high;
    // wr_ready is a registered !pending_full, so it falls the cycle after a transfer and
    // rises the cycle after the pending frame is committed. Data is ignored otherwise.
    always_comb begin
        act_digits_d  = act_digits_q;
        act_blank_d   = act_blank_q;
        pend_digits_d = pend_digits_q;
        pend_blank_d  = pend_blank_q;
        pend_full_d   = pend_full_q;
        if (commit && pend_full_q) begin
            act_digits_d = pend_digits_q;
            act_blank_d  = pend_blank_q;
            pend_full_d  = 1'b0;
        end
        if (wr_valid && wr_ready_q) begin
            pend_digits_d = wr_digits;
            pend_blank_d  = wr_blank;
            pend_full_d   = 1'b1;
        end
    end

    // Outputs are computed from next-state values so they register in step with the FSM.
    always_comb begin
        dec_code_d = dec_code_q;
        digit_en_d = '0;
        seg_off_d  = 1'b1;
        if (state_d == ST_SHOW) begin
            dec_code_d = act_digits_d[3*idx_d +: 3];
            if (!act_blank_d[idx_d]) begin
                digit_en_d = NUM_DIGITS'(1) << idx_d;
                seg_off_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_OFF;
            idx_q         <= '0;
            cnt_q         <= '0;
            act_digits_q  <= '0;
            act_blank_q   <= '1;
            pend_digits_q <= '0;
            pend_blank_q  <= '0;
            pend_full_q   <= 1'b0;
            wr_ready_q    <= 1'b1;
            dec_code_q    <= '0;
            digit_en_q    <= '0;
            seg_off_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            act_digits_q  <= act_digits_d;
            act_blank_q   <= act_blank_d;
            pend_digits_q <= pend_digits_d;
            pend_blank_q  <= pend_blank_d;
            pend_full_q   <= pend_full_d;
            wr_ready_q    <= !pend_full_d;
            dec_code_q    <= dec_code_d;
            digit_en_q    <= digit_en_d;
            seg_off_q     <= seg_off_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign dec_code  = dec_code_q;
    assign digit_en  = digit_en_q;
    assign seg_off   = seg_off_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller with 4 digits, 4-cycle slots, 1-cycle gap.
module tb_seven_seg_scan_controller;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int GC    = 1;
    localparam int SLOT  = RD + GC;
    localparam int FRAME = N * SLOT;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           wr_valid;
    logic           wr_ready;
    logic [3*N-1:0] wr_digits;
    logic [N-1:0]   wr_blank;
    logic [2:0]     dec_code;
    logic [N-1:0]   digit_en;
    logic           seg_off;
    logic [1:0]     dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [3*N-1:0] codes_a = 12'b011_010_001_000;
    logic [3*N-1:0] codes_7 = 12'b111_111_111_111;
    logic [3*N-1:0] codes_b = 12'b110_101_100_011;
    logic [3*N-1:0] codes_5 = 12'b101_101_101_101;
    logic [3*N-1:0] codes_6 = 12'b110_110_110_110;

    seven_seg_scan_controller #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .GAP_CYCLES (GC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_digits(wr_digits),
        .wr_blank (wr_blank),
        .dec_code (dec_code),
        .digit_en (digit_en),
        .seg_off  (seg_off),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Expected {seg_off, dec_code, digit_en} for cycle c counted from a digit-0 slot start.
    function automatic logic [7:0] exp_out(int c, logic [3*N-1:0] codes, logic [N-1:0] blank);
        int pos = c % FRAME;
        int d   = pos / SLOT;
        int s   = pos % SLOT;
        logic [2:0]   code = codes[3*d +: 3];
        logic [N-1:0] den  = '0;
        logic         so   = 1'b1;
        if (s < RD && !blank[d]) begin
            den = N'(1) << d;
            so  = 1'b0;
        end
        return {so, code, den};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_digits = '0; wr_blank = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({seg_off, dec_code, digit_en, wr_ready} !== {1'b1, 3'd0, 4'b0000, 1'b1}) begin
                err_cnt++;
                $display("FAIL reset_idle cyc=%0d got seg=%b code=%0d en=%b rdy=%b exp seg=1 code=0 en=0000 rdy=1",
                         i, seg_off, dec_code, digit_en, wr_ready);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [7:0] e;
        wr_valid = 1'b1; wr_digits = codes_a; wr_blank = '0;
        @(negedge clk);
        wr_valid = 1'b0; wr_digits = 12'h123;
        vec_cnt++;
        if (wr_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_ready_drop got %b exp 0", wr_ready);
        end
        @(negedge clk);
        vec_cnt++;
        if (wr_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_off_commit_ready got %b exp 1", wr_ready);
        end
        en = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) begin
            @(negedge clk);
            e = exp_out(c, codes_a, '0);
            vec_cnt++;
            if ({seg_off, dec_code, digit_en, wr_ready} !== {e, 1'b1}) begin
                err_cnt++;
                $display("FAIL basic_scan c=%0d got %b_%0d_%b rdy=%b exp %b_%0d_%b rdy=1",
                         c, seg_off, dec_code, digit_en, wr_ready, e[7], e[6:4], e[3:0]);
            end
        end
    endtask

    task automatic test_tear_free();
        logic [7:0] e;
        logic       r;
        for (int c = FRAME + 4; c < 3 * FRAME; c++) begin
            @(negedge clk);
            e = exp_out(c, (c < 2 * FRAME) ? codes_a : codes_7, '0);
            r = !(c >= FRAME + 7 && c < 2 * FRAME);
            vec_cnt++;
            if ({seg_off, dec_code, digit_en, wr_ready} !== {e, r}) begin
                err_cnt++;
                $display("FAIL tear_free c=%0d got %b_%0d_%b rdy=%b exp %b_%0d_%b rdy=%b",
                         c, seg_off, dec_code, digit_en, wr_ready, e[7], e[6:4], e[3:0], r);
            end
            wr_valid = (c == FRAME + 6);
            wr_digits = (c == FRAME + 6) ? codes_7 : 12'h5A5;
        end
    endtask

    task automatic test_blank();
        logic [7:0] e;
        logic       r;
        wr_valid = 1'b1; wr_digits = codes_b; wr_blank = 4'b0101;
        for (int c = 3 * FRAME; c < 5 * FRAME; c++) begin
            @(negedge clk);
            wr_valid = 1'b0; wr_digits = 12'hFFF; wr_blank = 4'b1111;
            e = (c < 4 * FRAME) ? exp_out(c, codes_7, '0) : exp_out(c, codes_b, 4'b0101);
            r = (c >= 4 * FRAME);
            vec_cnt++;
            if ({seg_off, dec_code, digit_en, wr_ready} !== {e, r}) begin
                err_cnt++;
                $display("FAIL blank_mask c=%0d got %b_%0d_%b rdy=%b exp %b_%0d_%b rdy=%b",
                         c, seg_off, dec_code, digit_en, wr_ready, e[7], e[6:4], e[3:0], r);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] e;
        logic       r;
        for (int c = 5 * FRAME; c < 5 * FRAME + 12; c++) begin
            @(negedge clk);
            e = exp_out(c, codes_b, 4'b0101);
            r = (c <= 5 * FRAME + 10);
            vec_cnt++;
            if ({seg_off, dec_code, digit_en, wr_ready} !== {e, r}) begin
                err_cnt++;
                $display("FAIL drop_pre c=%0d got %b_%0d_%b rdy=%b exp %b_%0d_%b rdy=%b",
                         c, seg_off, dec_code, digit_en, wr_ready, e[7], e[6:4], e[3:0], r);
            end
            if (c == 5 * FRAME + 10) begin
                wr_valid = 1'b1; wr_digits = codes_5; wr_blank = '0;
            end else begin
                wr_valid = 1'b0; wr_digits = 12'h000; wr_blank = 4'b1111;
            end
        end
        en = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({seg_off, digit_en, wr_ready} !== {1'b1, 4'b0000, 1'b0}) begin
            err_cnt++;
            $display("FAIL drop_off got seg=%b en=%b rdy=%b exp seg=1 en=0000 rdy=0", seg_off, digit_en, wr_ready);
        end
        @(negedge clk);
        vec_cnt++;
        if ({seg_off, digit_en, wr_ready} !== {1'b1, 4'b0000, 1'b1}) begin
            err_cnt++;
            $display("FAIL drop_off_commit got seg=%b en=%b rdy=%b exp seg=1 en=0000 rdy=1", seg_off, digit_en, wr_ready);
        end
        en = 1'b1;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            e = exp_out(c, codes_5, '0);
            vec_cnt++;
            if ({seg_off, dec_code, digit_en, wr_ready} !== {e, 1'b1}) begin
                err_cnt++;
                $display("FAIL drop_reenable c=%0d got %b_%0d_%b rdy=%b exp %b_%0d_%b rdy=1",
                         c, seg_off, dec_code, digit_en, wr_ready, e[7], e[6:4], e[3:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = exp_out(c, codes_5, '0);
            vec_cnt++;
            if ({seg_off, dec_code, digit_en} !== e) begin
                err_cnt++;
                $display("FAIL rst_pre c=%0d got %b_%0d_%b exp %b_%0d_%b",
                         c, seg_off, dec_code, digit_en, e[7], e[6:4], e[3:0]);
            end
        end
        wr_valid = 1'b1; wr_digits = codes_6; wr_blank = '0;
        @(negedge clk);
        wr_valid = 1'b0;
        vec_cnt++;
        if (wr_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_pending_ready got %b exp 0", wr_ready);
        end
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({seg_off, dec_code, digit_en, wr_ready} !== {1'b1, 3'd0, 4'b0000, 1'b1}) begin
            err_cnt++;
            $display("FAIL rst_immediate got seg=%b code=%0d en=%b rdy=%b exp seg=1 code=0 en=0000 rdy=1",
                     seg_off, dec_code, digit_en, wr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            e = exp_out(c, '0, 4'b1111);
            vec_cnt++;
            if ({seg_off, dec_code, digit_en, wr_ready} !== {e, 1'b1}) begin
                err_cnt++;
                $display("FAIL rst_post c=%0d got %b_%0d_%b rdy=%b exp %b_%0d_%b rdy=1",
                         c, seg_off, dec_code, digit_en, wr_ready, e[7], e[6:4], e[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_blank();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
